// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch prefetch unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package if_pkg;

    localparam int          XLEN_DEF = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEF-1:0] addr;
        logic [XLEN_DEF-1:0] inst;
    } fifo_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO with push, pop, clear and occupancy count; power-of-two depth.
// Latency: a pushed entry is visible at dout the cycle after the push (no fall-through).
// Backpressure: push is dropped when full unless a pop happens the same cycle; clear overrides both.
module inst_fifo #(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_prefetch.sv
// Pipelined instruction fetch: PC generation, credit-limited ROM requests, prefetch queue to if_id.
// Latency: grant at N, rvalid at N+L -> inst_valid_o at N+L+1. Optional feature: IF_PREFETCH_MISALIGN_EN.
// Backpressure: requests only while queue entries + in-flight responses < FIFO_DEPTH; redirects flush.
module if_prefetch
    import if_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            rom_req_o,
    output logic [XLEN-1:0] rom_addr_o,
    input  logic            rom_gnt_i,
    input  logic            rom_rvalid_i,
    input  logic [XLEN-1:0] rom_rdata_i,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o
`ifdef IF_PREFETCH_MISALIGN_EN
    ,
    output logic            misalign_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] jump_target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            run;
    logic            halted;
    logic            grant;
    logic            rvalid;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    fifo_entry_t     push_entry;
    fifo_entry_t     head_entry;

`ifdef IF_PREFETCH_MISALIGN_EN
    assign jump_target = jump_addr_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
        end else if (jump_en_i) begin
            halted <= (jump_addr_i[1:0] != 2'b00);
        end
    end

    assign misalign_o = halted;
`else
    assign jump_target = jump_addr_i & ~XLEN'(3);
    assign halted      = 1'b0;
`endif

    // Responses arriving with nothing outstanding belong to a pre-reset ROM transaction.
    assign rvalid      = rom_rvalid_i && (outstanding != '0);
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign rom_req_o   = run && !jump_en_i && !halted && !fifo_full &&
                         (credit_used < (CW+1)'(FIFO_DEPTH));
    assign rom_addr_o  = pc;
    assign grant       = rom_req_o && rom_gnt_i;
    assign pop         = inst_valid_o && inst_ready_i && !jump_en_i;
    assign push        = rvalid && (discard == '0) && !jump_en_i;

    assign push_entry.addr = XLEN_DEF'(resp_pc);
    assign push_entry.inst = XLEN_DEF'(rom_rdata_i);

    inst_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (jump_en_i),
        .din   (push_entry),
        .dout  (head_entry),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign inst_valid_o = !fifo_empty;
    assign inst_o       = fifo_empty ? XLEN'(INST_NOP) : XLEN'(head_entry.inst);
    assign inst_addr_o  = fifo_empty ? '0 : XLEN'(head_entry.addr);

    // outstanding counts every in-flight response, including those marked for discard,
    // so discard never exceeds outstanding and both stay within FIFO_DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run         <= 1'b0;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding + CW'(grant) - CW'(rvalid);
            if (jump_en_i) begin
                pc      <= jump_target;
                resp_pc <= jump_target;
                discard <= outstanding - CW'(rvalid);
            end else begin
                if (grant) pc <= pc + XLEN'(4);
                if (push)  resp_pc <= resp_pc + XLEN'(4);
                if (rvalid && (discard != '0)) discard <= discard - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: table vectors, directed corner sequences, random run.
// ROM model returns responses in order with configurable latency; reference model tracks tagged requests.
`timescale 1ns/1ps
module tb_if_prefetch;
    import if_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i = 1'b0;
    logic        rom_rvalid_i = 1'b0;
    logic [31:0] rom_rdata_i = 32'h0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
`ifdef IF_PREFETCH_MISALIGN_EN
    logic        misalign_o;
`endif

    always #5 clk = ~clk;

    if_prefetch #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_gnt_i    (rom_gnt_i),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_rdata_i  (rom_rdata_i),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
`ifdef IF_PREFETCH_MISALIGN_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat_min = 1;
    int lat_max = 1;
    int last_due = 0;

    typedef struct { logic [31:0] addr; int due; } rom_req_t;
    rom_req_t rom_q[$];

    // Reference model: queue contents and in-flight requests tagged stale or live.
    logic [63:0] m_fifo[$];
    bit          m_infl[$];
    logic [31:0] m_pc;
    logic [31:0] m_rpc;
    bit          m_halt;

    logic        s_req, s_valid, s_mis;
    logic [31:0] s_addr, s_iaddr, s_inst;

    typedef struct {
        logic        jmp;
        logic [31:0] ja;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_iaddr;
    } vec_t;
    vec_t vt[11];

    function automatic logic [31:0] rom_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_infl.delete();
        m_pc   = 32'h0;
        m_rpc  = 32'h0;
        m_halt = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rom_q.delete();
        last_due = 0;
        model_reset();
        rom_rvalid_i = 1'b0; rom_rdata_i = 32'h0; rom_gnt_i = 1'b0;
        jump_en_i = 1'b0; jump_addr_i = 32'h0; inst_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk1("reset_req", rom_req_o, 1'b0);
        chk1("reset_valid", inst_valid_o, 1'b0);
        chk("reset_inst", inst_o, INST_NOP);
        chk("reset_iaddr", inst_addr_o, 32'h0);
`ifdef IF_PREFETCH_MISALIGN_EN
        chk1("reset_misalign", misalign_o, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cyc = 0;
    endtask

    // One clock cycle: drive at negedge, sample and compare 1ns later, advance ROM and model.
    task automatic step(input logic jmp, input logic [31:0] ja, input logic rdy, input logic g);
        logic        exp_req, exp_valid;
        logic [31:0] exp_iaddr, exp_inst, ja_eff;
        bit          stale;
        logic [63:0] e;
        rom_req_t    r;
        int          due;
        rom_rvalid_i = (rom_q.size() > 0) && (rom_q[0].due <= cyc);
        rom_rdata_i  = rom_rvalid_i ? rom_data(rom_q[0].addr) : 32'h0;
        jump_en_i = jmp; jump_addr_i = ja; inst_ready_i = rdy; rom_gnt_i = g;
        #1;
        s_req = rom_req_o; s_addr = rom_addr_o; s_valid = inst_valid_o;
        s_iaddr = inst_addr_o; s_inst = inst_o;
`ifdef IF_PREFETCH_MISALIGN_EN
        s_mis = misalign_o;
`else
        s_mis = 1'b0;
`endif
        exp_req   = !jmp && !m_halt && ((m_fifo.size() + m_infl.size()) < DEPTH);
        exp_valid = m_fifo.size() > 0;
        exp_iaddr = exp_valid ? m_fifo[0][63:32] : 32'h0;
        exp_inst  = exp_valid ? m_fifo[0][31:0] : INST_NOP;
        chk1("model_req", s_req, exp_req);
        chk("model_rom_addr", s_addr, m_pc);
        chk1("model_valid", s_valid, exp_valid);
        chk("model_iaddr", s_iaddr, exp_iaddr);
        chk("model_inst", s_inst, exp_inst);
`ifdef IF_PREFETCH_MISALIGN_EN
        chk1("model_misalign", s_mis, m_halt);
`endif
        // ROM side reacts to what the DUT actually drives.
        if (rom_rvalid_i) r = rom_q.pop_front();
        if (rom_req_o && rom_gnt_i) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rom_q.push_back('{rom_addr_o, due});
        end
        stale = 1'b1;
        if (rom_rvalid_i && m_infl.size() > 0) stale = m_infl.pop_front();
        if (jmp) begin
            m_fifo.delete();
            foreach (m_infl[i]) m_infl[i] = 1'b1;
`ifdef IF_PREFETCH_MISALIGN_EN
            ja_eff = ja;
            m_halt = (ja[1:0] != 2'b00);
`else
            ja_eff = ja & 32'hFFFF_FFFC;
`endif
            m_pc  = ja_eff;
            m_rpc = ja_eff;
        end else begin
            if (exp_valid && rdy) e = m_fifo.pop_front();
            if (rom_rvalid_i && !stale) begin
                m_fifo.push_back({m_rpc, rom_rdata_i});
                m_rpc = m_rpc + 32'd4;
            end
            if (exp_req && g) begin
                m_infl.push_back(1'b0);
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int n_gnt;
        int bad;
        logic [31:0] first_addr;
        bit got_first;

        // L=1, ready high then a low stretch to fill the queue, then drain.
        vt[0]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vt[1]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vt[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vt[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vt[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vt[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        vt[6]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
        vt[7]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
        vt[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
        vt[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 1'b1, 32'h10};
        vt[10] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(vt[i].jmp, vt[i].ja, vt[i].rdy, 1'b1);
            chk1("tbl_req", s_req, vt[i].exp_req);
            chk("tbl_rom_addr", s_addr, vt[i].exp_addr);
            chk1("tbl_valid", s_valid, vt[i].exp_valid);
            if (vt[i].exp_valid) begin
                chk("tbl_iaddr", s_iaddr, vt[i].exp_iaddr);
                chk("tbl_inst", s_inst, rom_data(vt[i].exp_iaddr));
            end
        end

        // Credit limit: L=3, consumer stalled.
        lat_min = 3; lat_max = 3;
        do_reset();
        n_gnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            if (s_req) n_gnt++;
        end
        chk("credit_grants", 32'(n_gnt), 32'd4);
        chk1("credit_req_low", s_req, 1'b0);
        chk1("credit_valid", s_valid, 1'b1);
        chk("credit_head", s_iaddr, 32'h0);

        // Redirect with two requests in flight at L=3.
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        got_first = 1'b0; first_addr = 32'h0; bad = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (s_valid && !got_first) begin got_first = 1'b1; first_addr = s_iaddr; end
            if (s_valid && s_iaddr < 32'h100) bad++;
        end
        chk("redir_first_addr", first_addr, 32'h100);
        chk("redir_stale_seen", 32'(bad), 32'd0);

        // Redirect coinciding with rvalid and a pop, L=2.
        lat_min = 2; lat_max = 2;
        do_reset();
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h40, 1'b1, 1'b1);
        chk1("coinc_valid_before", s_valid, 1'b1);
        chk1("coinc_rvalid", rom_rvalid_i, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk1("coinc_flushed", s_valid, 1'b0);
        got_first = 1'b0; first_addr = 32'h0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (s_valid && !got_first) begin got_first = 1'b1; first_addr = s_iaddr; end
            if (s_valid && s_iaddr < 32'h40) bad++;
        end
        chk("coinc_first_addr", first_addr, 32'h40);
        chk("coinc_stale_seen", 32'(bad), 32'd0);

        // PC wrap.
        lat_min = 1; lat_max = 1;
        do_reset();
        step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_addr1", s_addr, 32'h0);

`ifdef IF_PREFETCH_MISALIGN_EN
        do_reset();
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h102, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk1("mis_flag", s_mis, 1'b1);
        chk1("mis_req", s_req, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk1("mis_req_held", s_req, 1'b0);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk1("mis_clear", s_mis, 1'b0);
        chk1("mis_resume_req", s_req, 1'b1);
        chk("mis_resume_addr", s_addr, 32'h200);
`endif

        // Random traffic against the model, with a reset in the middle.
        lat_min = 1; lat_max = 4;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int i = 0; i < 1500; i++) begin
                logic        j;
                logic [31:0] a;
                j = ($urandom_range(99, 0) < 4);
                a = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                : ($urandom & 32'h0000_0FFF);
                step(j, a, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
